// File: rtl/feature_loader_pkg.sv
// Shared constants for the feature loader and the regression datapath it feeds.
package feature_loader_pkg;

    localparam int FEAT_W_DEF   = 16;
    localparam int NUM_FEAT_DEF = 3;
    localparam int CNT_W_DEF    = 16;

    localparam logic [0:0] ST_FILL   = 1'b0;
    localparam logic [0:0] ST_RESYNC = 1'b1;

    // Keeps the word index at least one bit wide when a sample is a single word
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/feature_loader_if.sv
// Word stream in, feature vector out, plus error/status signals of the loader.
interface feature_loader_if
    import feature_loader_pkg::*;
#(
    parameter int FEAT_W   = FEAT_W_DEF,
    parameter int NUM_FEAT = NUM_FEAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) ();

    logic                       in_valid;
    logic                       in_ready;
    logic [FEAT_W-1:0]          in_data;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_FEAT*FEAT_W-1:0] out_feat;
    logic                       frame_err;
    logic                       err_clr;
    logic [CNT_W-1:0]           sample_cnt;

    modport master (
        output in_valid, in_data, in_last, out_ready, err_clr,
        input  in_ready, out_valid, out_feat, frame_err, sample_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready, err_clr,
        output in_ready, out_valid, out_feat, frame_err, sample_cnt
    );

endinterface

// File: rtl/feat_capture_buf.sv
// Write-indexed capture registers; load_vec already includes the word being written
// this cycle so a completing sample can move to the output without an extra cycle.
module feat_capture_buf
    import feature_loader_pkg::*;
#(
    parameter int FEAT_W   = FEAT_W_DEF,
    parameter int NUM_FEAT = NUM_FEAT_DEF,
    parameter int IDX_W    = idx_width(NUM_FEAT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [FEAT_W-1:0]          wr_data,
    output logic [NUM_FEAT*FEAT_W-1:0] load_vec
);

    logic [FEAT_W-1:0] slot [NUM_FEAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_FEAT; k++) begin
                slot[k] <= '0;
            end
        end else if (wr_en) begin
            slot[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        load_vec = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
            load_vec[k*FEAT_W +: FEAT_W] = (wr_en && (wr_idx == IDX_W'(k))) ? wr_data : slot[k];
        end
    end

endmodule

// File: rtl/feature_loader.sv
// Assembles serial feature words into a held feature vector, double-buffered,
// with framing-error detection and resynchronisation on the next in_last.
module feature_loader
    import feature_loader_pkg::*;
#(
    parameter int FEAT_W   = FEAT_W_DEF,
    parameter int NUM_FEAT = NUM_FEAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input logic              clk,
    input logic              rst,
    feature_loader_if.slave  bus
);

    localparam int               IDX_W    = idx_width(NUM_FEAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    logic [0:0]                 state;
    logic [IDX_W-1:0]           idx;
    logic                       cap_full;
    logic                       running;
    logic                       out_valid_q;
    logic [NUM_FEAT*FEAT_W-1:0] out_feat_q;
    logic                       frame_err_q;
    logic [CNT_W-1:0]           sample_cnt_q;
    logic [NUM_FEAT*FEAT_W-1:0] load_vec;

    logic in_fire, out_fire, fill_fire, at_last;
    logic complete, short_err, long_err, load_out;

    // running holds in_ready low for the first cycle after reset release
    assign bus.in_ready = running && ((state == ST_RESYNC) || !cap_full);

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = out_valid_q && bus.out_ready;
    assign fill_fire = in_fire && (state == ST_FILL);
    assign at_last   = (idx == LAST_IDX);
    assign complete  = fill_fire && bus.in_last && at_last;
    assign short_err = fill_fire && bus.in_last && !at_last;
    assign long_err  = fill_fire && !bus.in_last && at_last;
    assign load_out  = (cap_full && out_fire) || (complete && (!out_valid_q || out_fire));

    feat_capture_buf #(
        .FEAT_W   (FEAT_W),
        .NUM_FEAT (NUM_FEAT),
        .IDX_W    (IDX_W)
    ) u_capture (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fill_fire),
        .wr_idx   (idx),
        .wr_data  (bus.in_data),
        .load_vec (load_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FILL;
            idx      <= '0;
            cap_full <= 1'b0;
            running  <= 1'b0;
        end else begin
            running <= 1'b1;
            if (state == ST_FILL) begin
                if (fill_fire) begin
                    idx <= (bus.in_last || at_last) ? '0 : idx + 1'b1;
                    if (long_err) begin
                        state <= ST_RESYNC;
                    end
                end
            end else if (in_fire && bus.in_last) begin
                state <= ST_FILL;
            end
            // A finished sample that cannot move out waits in the capture buffer
            if (complete && out_valid_q && !out_fire) begin
                cap_full <= 1'b1;
            end else if (out_fire) begin
                cap_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_feat_q   <= '0;
            frame_err_q  <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            if (load_out) begin
                out_valid_q <= 1'b1;
                out_feat_q  <= load_vec;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
            if (short_err || long_err) begin
                frame_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                frame_err_q <= 1'b0;
            end
            if (out_fire) begin
                sample_cnt_q <= sample_cnt_q + 1'b1;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_feat   = out_feat_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_feature_loader.sv
// Self-checking bench for feature_loader: directed scenarios plus randomized
// framing against a word-list reference model of sample assembly.
module tb_feature_loader;

    localparam int FW = 16;
    localparam int NF = 3;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    int stall_cycles = 0;
    int got_rd = 0;
    int exp_rd = 0;

    logic [NF*FW-1:0] got_q[$];
    logic [NF*FW-1:0] exp_q[$];
    logic [FW-1:0]    part_q[$];
    bit               m_resync = 1'b0;
    bit               exp_err  = 1'b0;
    logic [NF*FW-1:0] mon_vec;
    bit               mon_evt;

    feature_loader_if #(.FEAT_W(FW), .NUM_FEAT(NF), .CNT_W(CW)) bus ();

    feature_loader #(.FEAT_W(FW), .NUM_FEAT(NF), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: collects accepted words into frames and applies the framing rules
    always @(negedge clk) begin
        mon_evt = 1'b0;
        if (rst) begin
            part_q.delete();
            m_resync = 1'b0;
            exp_err  = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_feat);
            if (bus.in_valid && bus.in_ready) begin
                if (m_resync) begin
                    if (bus.in_last) m_resync = 1'b0;
                end else begin
                    part_q.push_back(bus.in_data);
                    if (bus.in_last) begin
                        if (part_q.size() == NF) begin
                            for (int k = 0; k < NF; k++) mon_vec[k*FW +: FW] = part_q[k];
                            exp_q.push_back(mon_vec);
                        end else begin
                            mon_evt = 1'b1;
                        end
                        part_q.delete();
                    end else if (part_q.size() == NF) begin
                        mon_evt  = 1'b1;
                        m_resync = 1'b1;
                        part_q.delete();
                    end
                end
            end
            if (mon_evt) exp_err = 1'b1;
            else if (bus.err_clr) exp_err = 1'b0;
        end
    end

    task automatic send_word(input logic [FW-1:0] d, input logic last, input bit rnd_ready);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && t < 60) begin
            if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            t++;
        end
        stall_cycles += t;
        n_checks++;
        if (t >= 60) begin
            n_fail++;
            $display("[TB] FAIL in_ready_wait: waited %0d cycles, required < 60", t);
        end
        if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_data  = FW'($urandom);
        bus.in_last  = 1'($urandom_range(0, 1));
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b0; bus.err_clr = 1'b0;
        #2;
        n_checks += 5;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_feat !== '0) begin n_fail++; $display("[TB] FAIL rst_out_feat: got %h want 0", bus.out_feat); end
        if (bus.frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_frame_err: got %b want 0", bus.frame_err); end
        if (bus.sample_cnt !== '0) begin n_fail++; $display("[TB] FAIL rst_sample_cnt: got %0d want 0", bus.sample_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_release_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        send_word(16'h0001, 1'b0, 1'b0);
        send_word(16'h0002, 1'b0, 1'b0);
        send_word(16'h0003, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        n_checks += 2;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid: got %b want 1", bus.out_valid); end
        if (bus.out_feat !== 48'h0003_0002_0001) begin n_fail++; $display("[TB] FAIL basic_feat: got %h want 000300020001", bus.out_feat); end
        idle(1);
        exp_cnt += 1;
        n_checks += 3;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_valid_drop: got %b want 0", bus.out_valid); end
        if (bus.sample_cnt !== CW'(exp_cnt)) begin n_fail++; $display("[TB] FAIL basic_cnt: got %0d want %0d", bus.sample_cnt, exp_cnt); end
        if (got_q.size() - got_rd != exp_q.size() - exp_rd) begin n_fail++; $display("[TB] FAIL basic_count: got %0d samples want %0d", got_q.size() - got_rd, exp_q.size() - exp_rd); end
        while (got_rd < got_q.size() && exp_rd < exp_q.size()) begin
            n_checks++;
            if (got_q[got_rd] !== exp_q[exp_rd]) begin n_fail++; $display("[TB] FAIL basic_model: got %h want %h", got_q[got_rd], exp_q[exp_rd]); end
            got_rd++; exp_rd++;
        end
        got_rd = got_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_backpressure();
        logic [FW-1:0]    w;
        logic [NF*FW-1:0] va, vb;
        bus.out_ready = 1'b0;
        for (int k = 0; k < NF; k++) begin
            w = FW'($urandom); va[k*FW +: FW] = w;
            send_word(w, (k == NF - 1), 1'b0);
        end
        n_checks += 2;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_first_valid: got %b want 1", bus.out_valid); end
        if (bus.out_feat !== va) begin n_fail++; $display("[TB] FAIL bp_first_feat: got %h want %h", bus.out_feat, va); end
        for (int k = 0; k < NF; k++) begin
            w = FW'($urandom); vb[k*FW +: FW] = w;
            send_word(w, (k == NF - 1), 1'b0);
        end
        n_checks += 2;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_full_ready: got %b want 0", bus.in_ready); end
        if (bus.out_feat !== va) begin n_fail++; $display("[TB] FAIL bp_hold_feat: got %h want %h", bus.out_feat, va); end
        bus.in_valid = 1'b1; bus.in_data = FW'($urandom); bus.in_last = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks += 3;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_stall_ready: got %b want 0", bus.in_ready); end
        if (bus.out_feat !== va) begin n_fail++; $display("[TB] FAIL bp_stall_feat: got %h want %h", bus.out_feat, va); end
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_stall_valid: got %b want 1", bus.out_valid); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks += 3;
        if (bus.out_feat !== vb) begin n_fail++; $display("[TB] FAIL bp_second_feat: got %h want %h", bus.out_feat, vb); end
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_second_valid: got %b want 1", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_back: got %b want 1", bus.in_ready); end
        idle(1);
        exp_cnt += 2;
        n_checks += 3;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drain_valid: got %b want 0", bus.out_valid); end
        if (bus.sample_cnt !== CW'(exp_cnt)) begin n_fail++; $display("[TB] FAIL bp_cnt: got %0d want %0d", bus.sample_cnt, exp_cnt); end
        if (got_q.size() - got_rd != exp_q.size() - exp_rd) begin n_fail++; $display("[TB] FAIL bp_count: got %0d samples want %0d", got_q.size() - got_rd, exp_q.size() - exp_rd); end
        while (got_rd < got_q.size() && exp_rd < exp_q.size()) begin
            n_checks++;
            if (got_q[got_rd] !== exp_q[exp_rd]) begin n_fail++; $display("[TB] FAIL bp_model: got %h want %h", got_q[got_rd], exp_q[exp_rd]); end
            got_rd++; exp_rd++;
        end
        got_rd = got_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_short_frame();
        bus.out_ready = 1'b1;
        send_word(16'h00AA, 1'b1, 1'b0);
        idle(1);
        n_checks += 2;
        if (bus.frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL short_err: got %b want 1", bus.frame_err); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL short_no_out: got %b want 0", bus.out_valid); end
        send_word(16'h1111, 1'b0, 1'b0);
        send_word(16'h2222, 1'b0, 1'b0);
        send_word(16'h3333, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_feat !== 48'h3333_2222_1111) begin n_fail++; $display("[TB] FAIL short_next_feat: got %h want 333322221111", bus.out_feat); end
        bus.err_clr = 1'b1;
        idle(1);
        bus.err_clr = 1'b0;
        exp_cnt += 1;
        n_checks += 2;
        if (bus.frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL short_clear: got %b want 0", bus.frame_err); end
        if (bus.sample_cnt !== CW'(exp_cnt)) begin n_fail++; $display("[TB] FAIL short_cnt: got %0d want %0d", bus.sample_cnt, exp_cnt); end
        got_rd = got_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_long_frame();
        bus.out_ready = 1'b1;
        send_word(16'h0A01, 1'b0, 1'b0);
        send_word(16'h0A02, 1'b0, 1'b0);
        send_word(16'h0A03, 1'b0, 1'b0);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL long_resync_ready: got %b want 1", bus.in_ready); end
        send_word(16'h0A04, 1'b1, 1'b0);
        idle(1);
        n_checks += 2;
        if (bus.frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL long_err: got %b want 1", bus.frame_err); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL long_no_out: got %b want 0", bus.out_valid); end
        send_word(16'h0B01, 1'b0, 1'b0);
        send_word(16'h0B02, 1'b0, 1'b0);
        send_word(16'h0B03, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_feat !== 48'h0B03_0B02_0B01) begin n_fail++; $display("[TB] FAIL long_next_feat: got %h want 0b030b020b01", bus.out_feat); end
        bus.err_clr = 1'b1;
        idle(1);
        bus.err_clr = 1'b0;
        exp_cnt += 1;
        n_checks++;
        if (bus.sample_cnt !== CW'(exp_cnt)) begin n_fail++; $display("[TB] FAIL long_cnt: got %0d want %0d", bus.sample_cnt, exp_cnt); end
        got_rd = got_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_err_collision();
        bus.err_clr = 1'b1;
        send_word(16'h00AA, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL collide_set_wins: got %b want 1", bus.frame_err); end
        idle(1);
        bus.err_clr = 1'b0;
        n_checks++;
        if (bus.frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL collide_clear: got %b want 0", bus.frame_err); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        stall_cycles = 0;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < NF; k++) send_word(FW'($urandom), (k == NF - 1), 1'b0);
        end
        idle(2);
        exp_cnt += 4;
        n_checks += 3;
        if (stall_cycles != 0) begin n_fail++; $display("[TB] FAIL b2b_stalls: got %0d stall cycles want 0", stall_cycles); end
        if (bus.sample_cnt !== CW'(exp_cnt)) begin n_fail++; $display("[TB] FAIL b2b_cnt: got %0d want %0d", bus.sample_cnt, exp_cnt); end
        if (got_q.size() - got_rd != exp_q.size() - exp_rd) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d samples want %0d", got_q.size() - got_rd, exp_q.size() - exp_rd); end
        while (got_rd < got_q.size() && exp_rd < exp_q.size()) begin
            n_checks++;
            if (got_q[got_rd] !== exp_q[exp_rd]) begin n_fail++; $display("[TB] FAIL b2b_model: got %h want %h", got_q[got_rd], exp_q[exp_rd]); end
            got_rd++; exp_rd++;
        end
        got_rd = got_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_random();
        int len;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, NF + 2);
            for (int w = 0; w < len; w++) begin
                send_word(FW'($urandom), (w == len - 1), 1'b1);
                if ($urandom_range(0, 2) == 0) begin
                    bus.err_clr = ($urandom_range(0, 7) == 0);
                    bus.out_ready = ($urandom_range(0, 1) != 0);
                    idle(1);
                    bus.err_clr = 1'b0;
                    n_checks++;
                    if (bus.frame_err !== exp_err) begin n_fail++; $display("[TB] FAIL rand_frame_err: got %b want %b", bus.frame_err, exp_err); end
                end
            end
        end
        bus.out_ready = 1'b1;
        idle(6);
        exp_cnt += exp_q.size() - exp_rd;
        n_checks += 3;
        if (bus.sample_cnt !== CW'(exp_cnt)) begin n_fail++; $display("[TB] FAIL rand_cnt: got %0d want %0d", bus.sample_cnt, exp_cnt); end
        if (bus.frame_err !== exp_err) begin n_fail++; $display("[TB] FAIL rand_err_end: got %b want %b", bus.frame_err, exp_err); end
        if (got_q.size() - got_rd != exp_q.size() - exp_rd) begin n_fail++; $display("[TB] FAIL rand_count: got %0d samples want %0d", got_q.size() - got_rd, exp_q.size() - exp_rd); end
        while (got_rd < got_q.size() && exp_rd < exp_q.size()) begin
            n_checks++;
            if (got_q[got_rd] !== exp_q[exp_rd]) begin n_fail++; $display("[TB] FAIL rand_model: got %h want %h", got_q[got_rd], exp_q[exp_rd]); end
            got_rd++; exp_rd++;
        end
        got_rd = got_q.size(); exp_rd = exp_q.size();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        send_word(16'h0C01, 1'b0, 1'b0);
        send_word(16'h0C02, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        n_checks += 5;
        if (bus.out_feat !== '0) begin n_fail++; $display("[TB] FAIL mid_rst_feat: got %h want 0", bus.out_feat); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_ready: got %b want 0", bus.in_ready); end
        if (bus.sample_cnt !== '0) begin n_fail++; $display("[TB] FAIL mid_rst_cnt: got %0d want 0", bus.sample_cnt); end
        if (bus.frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_err: got %b want 0", bus.frame_err); end
        @(posedge clk); #1;
        rst = 1'b0;
        got_rd = got_q.size(); exp_rd = exp_q.size();
        exp_cnt = 0;
        bus.out_ready = 1'b1;
        send_word(16'h0D01, 1'b0, 1'b0);
        send_word(16'h0D02, 1'b0, 1'b0);
        send_word(16'h0D03, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_feat !== 48'h0D03_0D02_0D01) begin n_fail++; $display("[TB] FAIL mid_fresh_feat: got %h want 0d030d020d01", bus.out_feat); end
        idle(1);
        n_checks++;
        if (bus.sample_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL mid_fresh_cnt: got %0d want 1", bus.sample_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_err_collision();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
